// File: rtl/vga_csr.sv
`default_nettype none
// ============================================================================
// Module   : vga_csr
// Brief    : VGA control/status registers with frame-boundary shadow commit,
//            frame counter and write-1-to-clear interrupt flags.
// Revision : 1.0 - initial release
// ============================================================================
module vga_csr #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] addr_write_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              read_en_i,
    input  logic [ADDR_W-1:0] addr_read_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              frame_start_i,
    input  logic              vblank_i,
    input  logic              underflow_i,
    output logic              enable_o,
    output logic              pattern_en_o,
    output logic [1:0]        pattern_sel_o,
    output logic [11:0]       bg_color_o,
    output logic [9:0]        cursor_x_o,
    output logic [9:0]        cursor_y_o,
    output logic              irq_o
);

    localparam logic [ADDR_W-1:0] c_addr_ctrl     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_addr_bg_color = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_addr_cursor   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_addr_status   = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_addr_irq_stat = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_addr_irq_en   = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] c_addr_commit   = ADDR_W'(6);

    logic [3:0]        r_ctrl_stg, r_ctrl_act;
    logic [11:0]       r_bg_stg, r_bg_act;
    logic [9:0]        r_cx_stg, r_cx_act;
    logic [9:0]        r_cy_stg, r_cy_act;
    logic              r_commit_pending;
    logic [15:0]       r_frame_cnt;
    logic [1:0]        r_irq_stat;
    logic [1:0]        r_irq_en;
    logic [DATA_W-1:0] r_data;

    logic              w_commit_req;
    logic [1:0]        w_irq_clr;
    logic [DATA_W-1:0] w_rd_mux;
    logic              w_unused_data;

    assign w_commit_req  = write_en_i && (addr_write_i == c_addr_commit) && data_i[0];
    assign w_irq_clr     = (write_en_i && (addr_write_i == c_addr_irq_stat)) ? data_i[1:0] : 2'b00;
    assign w_unused_data = ^{data_i[DATA_W-1:26], data_i[15:12]};

    // Staging registers are reported on read; the pipeline only ever sees the active copy.
    always_comb begin
        w_rd_mux = '0;
        case (addr_read_i)
            c_addr_ctrl:     w_rd_mux[3:0]   = r_ctrl_stg;
            c_addr_bg_color: w_rd_mux[11:0]  = r_bg_stg;
            c_addr_cursor:   begin
                w_rd_mux[9:0]   = r_cx_stg;
                w_rd_mux[25:16] = r_cy_stg;
            end
            c_addr_status:   begin
                w_rd_mux[0]     = r_commit_pending;
                w_rd_mux[1]     = vblank_i;
                w_rd_mux[31:16] = r_frame_cnt;
            end
            c_addr_irq_stat: w_rd_mux[1:0]   = r_irq_stat;
            c_addr_irq_en:   w_rd_mux[1:0]   = r_irq_en;
            default:         w_rd_mux        = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl_stg       <= '0;
            r_bg_stg         <= '0;
            r_cx_stg         <= '0;
            r_cy_stg         <= '0;
            r_irq_en         <= '0;
            r_data           <= '0;
        end else begin
            if (read_en_i) begin
                r_data <= w_rd_mux;
            end
            if (write_en_i) begin
                case (addr_write_i)
                    c_addr_ctrl:     r_ctrl_stg <= data_i[3:0];
                    c_addr_bg_color: r_bg_stg   <= data_i[11:0];
                    c_addr_cursor:   begin
                        r_cx_stg <= data_i[9:0];
                        r_cy_stg <= data_i[25:16];
                    end
                    c_addr_irq_en:   r_irq_en   <= data_i[1:0];
                    default:         ;
                endcase
            end
        end
    end

    // A pending commit is consumed by frame_start before a same-cycle COMMIT
    // write can re-arm it, so a commit issued on a frame edge waits one frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl_act       <= '0;
            r_bg_act         <= '0;
            r_cx_act         <= '0;
            r_cy_act         <= '0;
            r_commit_pending <= 1'b0;
        end else if (frame_start_i && r_commit_pending) begin
            r_ctrl_act       <= r_ctrl_stg;
            r_bg_act         <= r_bg_stg;
            r_cx_act         <= r_cx_stg;
            r_cy_act         <= r_cy_stg;
            r_commit_pending <= 1'b0;
        end else if (w_commit_req) begin
            r_commit_pending <= 1'b1;
        end
    end

    // Set events take priority over a same-cycle W1C clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_frame_cnt <= '0;
            r_irq_stat  <= '0;
        end else begin
            if (frame_start_i) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_irq_stat <= (r_irq_stat & ~w_irq_clr) | {underflow_i, frame_start_i};
        end
    end

    assign data_o        = r_data;
    assign enable_o      = r_ctrl_act[0];
    assign pattern_en_o  = r_ctrl_act[1];
    assign pattern_sel_o = r_ctrl_act[3:2];
    assign bg_color_o    = r_bg_act;
    assign cursor_x_o    = r_cx_act;
    assign cursor_y_o    = r_cy_act;
    assign irq_o         = |(r_irq_stat & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_vga_csr.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_csr
// Brief    : Self-checking bench for vga_csr against a register-map model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_csr;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        write_en_i = 1'b0;
    logic [2:0]  addr_write_i = '0;
    logic [31:0] data_i = '0;
    logic        read_en_i = 1'b0;
    logic [2:0]  addr_read_i = '0;
    logic [31:0] data_o;
    logic        frame_start_i = 1'b0;
    logic        vblank_i = 1'b0;
    logic        underflow_i = 1'b0;
    logic        enable_o, pattern_en_o, irq_o;
    logic [1:0]  pattern_sel_o;
    logic [11:0] bg_color_o;
    logic [9:0]  cursor_x_o, cursor_y_o;

    int n_checks = 0;
    int n_pass   = 0;

    vga_csr #(.DATA_W(32), .ADDR_W(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .write_en_i(write_en_i), .addr_write_i(addr_write_i), .data_i(data_i),
        .read_en_i(read_en_i), .addr_read_i(addr_read_i), .data_o(data_o),
        .frame_start_i(frame_start_i), .vblank_i(vblank_i), .underflow_i(underflow_i),
        .enable_o(enable_o), .pattern_en_o(pattern_en_o), .pattern_sel_o(pattern_sel_o),
        .bg_color_o(bg_color_o), .cursor_x_o(cursor_x_o), .cursor_y_o(cursor_y_o),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: the register map as named words, staging vs. active copies.
    logic [31:0] m_ctrl_s, m_bg_s, m_cur_s, m_ctrl_a, m_bg_a, m_cur_a;
    logic [31:0] m_stat, m_en, m_data;
    logic        m_pend;
    logic [15:0] m_fcnt;

    function automatic logic [31:0] model_read(input logic [2:0] a, input logic vb);
        case (a)
            3'd0:    return m_ctrl_s;
            3'd1:    return m_bg_s;
            3'd2:    return m_cur_s;
            3'd3:    return {m_fcnt, 14'd0, vb, m_pend};
            3'd4:    return m_stat;
            3'd5:    return m_en;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [36:0] model_outs();
        return {m_ctrl_a[0], m_ctrl_a[1], m_ctrl_a[3:2], m_bg_a[11:0],
                m_cur_a[9:0], m_cur_a[25:16], |(m_stat[1:0] & m_en[1:0])};
    endfunction

    function automatic logic [36:0] dut_outs();
        return {enable_o, pattern_en_o, pattern_sel_o, bg_color_o, cursor_x_o, cursor_y_o, irq_o};
    endfunction

    task automatic step(input logic rst, input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        input logic re, input logic [2:0] ra, input logic fs, input logic vb,
                        input logic uf);
        rst_i = rst; write_en_i = we; addr_write_i = wa; data_i = wd;
        read_en_i = re; addr_read_i = ra; frame_start_i = fs; vblank_i = vb; underflow_i = uf;
        if (rst) begin
            m_ctrl_s = 0; m_bg_s = 0; m_cur_s = 0; m_ctrl_a = 0; m_bg_a = 0; m_cur_a = 0;
            m_stat = 0; m_en = 0; m_data = 0; m_pend = 0; m_fcnt = 0;
        end else begin
            if (re) m_data = model_read(ra, vb);
            if (fs && m_pend) begin
                m_ctrl_a = m_ctrl_s; m_bg_a = m_bg_s; m_cur_a = m_cur_s; m_pend = 0;
            end else if (we && wa == 3'd6 && wd[0]) begin
                m_pend = 1;
            end
            if (fs) m_fcnt = m_fcnt + 16'd1;
            if (we && wa == 3'd4) m_stat = m_stat & ~(wd & 32'h3);
            if (fs) m_stat[0] = 1'b1;
            if (uf) m_stat[1] = 1'b1;
            if (we) begin
                case (wa)
                    3'd0: m_ctrl_s = wd & 32'h0000_000F;
                    3'd1: m_bg_s   = wd & 32'h0000_0FFF;
                    3'd2: m_cur_s  = wd & 32'h03FF_03FF;
                    3'd5: m_en     = wd & 32'h0000_0003;
                    default: ;
                endcase
            end
        end
        @(posedge clk_i);
        #1;
        rst_i = 0; write_en_i = 0; read_en_i = 0; frame_start_i = 0; underflow_i = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dut_outs() !== 37'd0) $display("FAIL reset_outs: got %h exp 0", dut_outs());
        else n_pass++;
        n_checks++;
        if (data_o !== 32'd0) $display("FAIL reset_data: got %h exp 0", data_o);
        else n_pass++;
        for (int a = 0; a < 8; a++) begin
            step(0, 0, 0, 0, 1, 3'(a), 0, 0, 0);
            n_checks++;
            if (data_o !== 32'd0) $display("FAIL reset_read addr %0d: got %h exp 0", a, data_o);
            else n_pass++;
        end
    endtask

    task automatic test_commit();
        step(0, 1, 3'd1, 32'h0000_0ABC, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3'd1, 0, 0, 0);
        n_checks++;
        if (data_o !== 32'h0000_0ABC || bg_color_o !== 12'h000)
            $display("FAIL bg_staging: data %h bg %h exp data 00000abc bg 000", data_o, bg_color_o);
        else n_pass++;
        step(0, 1, 3'd6, 32'h1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
        n_checks++;
        if (data_o[0] !== 1'b1) $display("FAIL commit_pending: got %b exp 1", data_o[0]);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (bg_color_o !== 12'hABC) $display("FAIL bg_commit: got %h exp abc", bg_color_o);
        else n_pass++;
        step(0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
        n_checks++;
        if (data_o !== 32'h0001_0000) $display("FAIL status_after_commit: got %h exp 00010000", data_o);
        else n_pass++;
    endtask

    task automatic test_read_during_write();
        step(0, 1, 3'd1, 32'hFFFF_F123, 1, 3'd1, 0, 0, 0);
        n_checks++;
        if (data_o !== 32'h0000_0ABC) $display("FAIL read_old_value: got %h exp 00000abc", data_o);
        else n_pass++;
        step(0, 0, 0, 0, 1, 3'd1, 0, 0, 0);
        n_checks++;
        if (data_o !== 32'h0000_0123) $display("FAIL read_new_value: got %h exp 00000123", data_o);
        else n_pass++;
    endtask

    task automatic test_commit_same_frame();
        step(0, 1, 3'd0, 32'hF, 0, 0, 0, 0, 0);
        step(0, 1, 3'd6, 32'h1, 0, 0, 1, 0, 0);
        n_checks++;
        if (enable_o !== 1'b0) $display("FAIL commit_same_frame_en: got %b exp 0", enable_o);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (enable_o !== 1'b1 || pattern_sel_o !== 2'd3 || pattern_en_o !== 1'b1)
            $display("FAIL commit_next_frame: en %b pen %b sel %0d exp 1 1 3",
                     enable_o, pattern_en_o, pattern_sel_o);
        else n_pass++;
    endtask

    task automatic test_irq();
        step(0, 1, 3'd4, 32'h3, 0, 0, 0, 0, 0);
        step(0, 1, 3'd5, 32'h1, 0, 0, 0, 0, 0);
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_idle: got %b exp 0", irq_o);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        n_checks++;
        if (irq_o !== 1'b1) $display("FAIL irq_frame: got %b exp 1", irq_o);
        else n_pass++;
        step(0, 1, 3'd4, 32'h1, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 3'd4, 0, 0, 0);
        n_checks++;
        if (irq_o !== 1'b1 || data_o[0] !== 1'b1)
            $display("FAIL irq_set_wins: irq %b stat %h exp irq 1 stat bit0 1", irq_o, data_o);
        else n_pass++;
        step(0, 1, 3'd4, 32'h1, 0, 0, 0, 0, 0);
        n_checks++;
        if (irq_o !== 1'b0) $display("FAIL irq_clear: got %b exp 0", irq_o);
        else n_pass++;
    endtask

    task automatic test_frame_wrap();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65536; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 3'd3, 0, 0, 0);
        n_checks++;
        if (data_o[31:16] !== 16'h0000) $display("FAIL frame_wrap: got %h exp 0000", data_o[31:16]);
        else n_pass++;
        step(0, 1, 3'd4, 32'h3, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 3'd4, 0, 0, 0);
        n_checks++;
        if (data_o !== 32'h2 || irq_o !== 1'b0)
            $display("FAIL underflow_masked: stat %h irq %b exp 00000002 0", data_o, irq_o);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        step(0, 1, 3'd2, 32'h01E0_0280, 0, 0, 0, 0, 0);
        step(0, 1, 3'd6, 32'h1, 1, 3'd2, 0, 0, 0);
        n_checks++;
        if (data_o !== 32'h01E0_0280) $display("FAIL cursor_staging: got %h exp 01e00280", data_o);
        else n_pass++;
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 3'd3, 0, 1, 0);
        n_checks++;
        if (data_o !== 32'h2) $display("FAIL status_after_reset: got %h exp 00000002", data_o);
        else n_pass++;
        step(0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 3'd3, 0, 1, 0);
        n_checks++;
        if (cursor_x_o !== 10'd0 || cursor_y_o !== 10'd0 || data_o[0] !== 1'b0)
            $display("FAIL reset_drops_commit: x %h y %h status %h exp 0 0 pending 0",
                     cursor_x_o, cursor_y_o, data_o);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [2:0] wa, ra;
        logic       rst, we, re, fs, uf, vb;
        logic [31:0] wd;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 1) == 1);
            re  = ($urandom_range(0, 2) != 0);
            fs  = ($urandom_range(0, 5) == 0);
            uf  = ($urandom_range(0, 9) == 0);
            vb  = ($urandom_range(0, 1) == 1);
            wa  = 3'($urandom_range(0, 7));
            ra  = 3'($urandom_range(0, 7));
            wd  = $urandom;
            step(rst, we, wa, wd, re, ra, fs, vb, uf);
            n_checks++;
            if (data_o !== m_data || dut_outs() !== model_outs())
                $display("FAIL random cycle %0d: data %h outs %h exp data %h outs %h",
                         i, data_o, dut_outs(), m_data, model_outs());
            else n_pass++;
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_commit();
        test_read_during_write();
        test_commit_same_frame();
        test_irq();
        test_frame_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
